// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared state encoding and default constants for the tick scheduler
package tick_sched_pkg;

   localparam int CNT_W      = 32;
   localparam int DEF_PERIOD = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - run control, period configuration and request/grant bundle
interface tick_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int CNT_W = tick_sched_pkg::CNT_W
);
   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_period;
   logic             cfg_ready;
   logic [NREQ-1:0]  req;
   logic             tick;
   logic [NREQ-1:0]  grant;
   logic             busy;

   modport master (
      output en, cfg_valid, cfg_period, req,
      input  cfg_ready, tick, grant, busy
   );

   modport slave (
      input  en, cfg_valid, cfg_period, req,
      output cfg_ready, tick, grant, busy
   );
endinterface

// File: rtl/tick_scheduler_rr_arbiter.sv
// rtl/tick_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic             found
);
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - periodic tick generator with round-robin grant issued on each tick
module tick_scheduler #(
   parameter int NREQ       = 4,
   parameter int CNT_W      = tick_sched_pkg::CNT_W,
   parameter int DEF_PERIOD = tick_sched_pkg::DEF_PERIOD
) (
   input logic             clk,
   input logic             rst_n,
   tick_scheduler_if.slave bus
);
   import tick_sched_pkg::*;

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] pend_period;
   logic             pend_valid;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic [NREQ-1:0]  arb_grant;
   logic             arb_found;
   logic             tick_q;
   logic [NREQ-1:0]  grant_q;
   logic             active;
   logic             wrap;

   assign active        = (state != IDLE);
   assign wrap          = active && (cnt == period);
   assign bus.busy      = active;
   assign bus.cfg_ready = !pend_valid;
   assign bus.tick      = tick_q;
   assign bus.grant     = grant_q;

   rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
      .req   (bus.req),
      .ptr   (ptr),
      .grant (arb_grant),
      .found (arb_found)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (arb_grant[i]) gnt_idx = PTR_W'(i);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.en) state_nxt = RUN;
         RUN:     if (!bus.en) state_nxt = DRAIN;
         // The final wrap ends the drain even if en has come back on that cycle.
         DRAIN:   if (wrap) state_nxt = IDLE;
                  else if (bus.en) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= CNT_W'(1);
         period      <= CNT_W'(DEF_PERIOD);
         pend_period <= '0;
         pend_valid  <= 1'b0;
         ptr         <= '0;
         tick_q      <= 1'b0;
         grant_q     <= '0;
      end else begin
         tick_q  <= wrap;
         grant_q <= wrap ? arb_grant : '0;
         if (wrap && arb_found)
            ptr <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
         if (!active || wrap) cnt <= CNT_W'(1);
         else                 cnt <= cnt + CNT_W'(1);
         // A pending period lands while idle or at a wrap; the wrap itself still used the old one.
         if (pend_valid && (!active || wrap)) begin
            period     <= pend_period;
            pend_valid <= 1'b0;
         end else if (bus.cfg_valid && !pend_valid) begin
            pend_valid  <= 1'b1;
            pend_period <= (bus.cfg_period == '0) ? CNT_W'(1) : bus.cfg_period;
         end
      end
   end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized and directed checks of tick_scheduler against a behavioural model
module tb_tick_scheduler;
   localparam int NREQ  = 4;
   localparam int CNT_W = 32;
   localparam int DEF_P = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   tick_scheduler_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

   tick_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: running/stopping flags, position in period, last granted requester.
   bit              m_active   = 1'b0;
   bit              m_stopping = 1'b0;
   int              m_cnt      = 1;
   int              m_period   = DEF_P;
   int              m_last     = NREQ - 1;
   int              m_pend[$];
   logic            m_tick     = 1'b0;
   logic [NREQ-1:0] m_grant    = '0;

   initial begin : model
      bit w;
      int idx;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_active = 1'b0; m_stopping = 1'b0; m_cnt = 1; m_period = DEF_P;
            m_last = NREQ - 1; m_pend.delete(); m_tick = 1'b0; m_grant = '0;
         end else begin
            w       = m_active && (m_cnt == m_period);
            m_tick  = w;
            m_grant = '0;
            if (w) begin
               for (int j = 1; j <= NREQ; j++) begin
                  idx = (m_last + j) % NREQ;
                  if (bus.req[idx]) begin
                     m_grant = NREQ'(1) << idx;
                     m_last  = idx;
                     break;
                  end
               end
            end
            if (m_pend.size() > 0 && (!m_active || w))
               m_period = m_pend.pop_front();
            else if (bus.cfg_valid && m_pend.size() == 0)
               m_pend.push_back((bus.cfg_period == 0) ? 1 : int'(bus.cfg_period));
            m_cnt = (!m_active || w) ? 1 : m_cnt + 1;
            if (!m_active) begin
               if (bus.en) begin m_active = 1'b1; m_stopping = 1'b0; end
            end else if (m_stopping && w) begin
               m_active = 1'b0;
            end else begin
               m_stopping = !bus.en;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("tick",      32'(bus.tick),      32'(m_tick));
            chk("grant",     32'(bus.grant),     32'(m_grant));
            chk("busy",      32'(bus.busy),      32'(m_active));
            chk("cfg_ready", 32'(bus.cfg_ready), (m_pend.size() == 0) ? 32'd1 : 32'd0);
         end
      end
   end

   logic [31:0]     ttr, btr, rtr;
   logic [NREQ-1:0] gtr [0:31];

   task automatic clear_trace();
      ttr = '0; btr = '0; rtr = '0;
      for (int i = 0; i < 32; i++) gtr[i] = '0;
   endtask

   task automatic sample(input int k);
      @(negedge clk);
      ttr[k] = bus.tick; btr[k] = bus.busy; rtr[k] = bus.cfg_ready; gtr[k] = bus.grant;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.req = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      clear_trace();
   endtask

   task automatic set_period_idle(input int p);
      @(negedge clk); bus.cfg_valid = 1'b1; bus.cfg_period = CNT_W'(p);
      @(negedge clk); bus.cfg_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tick"},  32'(bus.tick),      32'd0);
      chk({tag, "_grant"}, 32'(bus.grant),     32'd0);
      chk({tag, "_busy"},  32'(bus.busy),      32'd0);
      chk({tag, "_ready"}, 32'(bus.cfg_ready), 32'd1);
   endtask

   int bias;

   initial begin
      bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.req = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      chk_reset_outputs("reset");

      // Default period 4, single requester.
      do_reset();
      @(negedge clk); bus.en = 1'b1; bus.req = 4'b0001;
      for (int k = 1; k <= 12; k++) sample(k);
      chk("A_ticks", ttr & 32'h1FFE, 32'h0000_0220);
      chk("A_grant5", 32'(gtr[5]), 32'h1);
      chk("A_grant9", 32'(gtr[9]), 32'h1);

      // Period 3, all requesting: rotation 0,1,2,3,0.
      do_reset();
      set_period_idle(3);
      bus.en = 1'b1; bus.req = 4'b1111;
      for (int k = 1; k <= 16; k++) sample(k);
      chk("B_ticks", ttr & 32'h1FFFE, 32'h0001_2490);
      chk("B_g1", 32'(gtr[4]),  32'h1);
      chk("B_g2", 32'(gtr[7]),  32'h2);
      chk("B_g3", 32'(gtr[10]), 32'h4);
      chk("B_g4", 32'(gtr[13]), 32'h8);
      chk("B_g5", 32'(gtr[16]), 32'h1);

      // Period 6 shortened to 2 mid-period.
      do_reset();
      set_period_idle(6);
      bus.en = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         sample(k);
         if (k == 2) begin bus.cfg_valid = 1'b1; bus.cfg_period = 32'd2; end
         if (k == 3) bus.cfg_valid = 1'b0;
      end
      chk("C_ticks", ttr & 32'h7FFE, 32'h0000_2A80);
      chk("C_ready", rtr & 32'h7FFE, 32'h0000_7F86);

      // Stop at count 2 of period 5.
      do_reset();
      set_period_idle(5);
      bus.en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         sample(k);
         if (k == 2) bus.en = 1'b0;
      end
      chk("D_ticks", ttr & 32'h7FE, 32'h0000_0040);
      chk("D_busy",  btr & 32'h7FE, 32'h0000_003E);

      // Stop then resume within one period: no cadence gap.
      do_reset();
      @(negedge clk); bus.en = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         sample(k);
         if (k == 2) bus.en = 1'b0;
         if (k == 3) bus.en = 1'b1;
      end
      chk("E_ticks", ttr & 32'h7FFE, 32'h0000_2220);
      chk("E_busy",  btr & 32'h7FFE, 32'h0000_7FFE);

      // Period 0 stored as 1: continuous tick.
      do_reset();
      set_period_idle(0);
      bus.en = 1'b1; bus.req = 4'b0100;
      for (int k = 1; k <= 8; k++) sample(k);
      chk("F_ticks", ttr & 32'h1FE, 32'h0000_01FC);
      chk("F_g2", 32'(gtr[2]), 32'h4);
      chk("F_g8", 32'(gtr[8]), 32'h4);

      // Second offer while pending is ignored.
      do_reset();
      @(negedge clk); bus.en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         sample(k);
         if (k == 1) begin bus.cfg_valid = 1'b1; bus.cfg_period = 32'd2; end
         if (k == 2) bus.cfg_period = 32'd7;
         if (k == 4) bus.cfg_valid = 1'b0;
      end
      chk("G_ticks", ttr & 32'h7FE, 32'h0000_02A0);
      chk("G_ready", rtr & 32'h7FE, 32'h0000_07E2);

      // Reset at count 3 with a pending config, then a tick in flight.
      do_reset();
      @(negedge clk); bus.en = 1'b1; bus.req = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         sample(k);
         if (k == 2) begin bus.cfg_valid = 1'b1; bus.cfg_period = 32'd2; end
         if (k == 3) bus.cfg_valid = 1'b0;
      end
      chk("H_pending", 32'(rtr[3]), 32'd0);
      #2 rst_n = 1'b0; bus.en = 1'b0;
      #1 chk_reset_outputs("H_rst3");
      @(negedge clk); #2 rst_n = 1'b1;
      clear_trace();
      @(negedge clk); bus.en = 1'b1;
      for (int k = 1; k <= 9; k++) sample(k);
      chk("H_ticks", ttr & 32'h3FE, 32'h0000_0220);
      chk("H_g9", 32'(gtr[9]), 32'h1);
      #2 rst_n = 1'b0; bus.en = 1'b0;
      #1 chk_reset_outputs("H_inflight");
      @(negedge clk); #2 rst_n = 1'b1;

      // Randomized traffic with occasional resets.
      bias = 6;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 40 == 0) bias = $urandom_range(1, 8);
         bus.en         = ($urandom_range(0, 7) < bias);
         bus.cfg_valid  = ($urandom_range(0, 11) == 0);
         bus.cfg_period = CNT_W'($urandom_range(0, 6));
         bus.req        = NREQ'($urandom);
         if ($urandom_range(0, 249) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the tick.
REQ-002 Parameter CNT_W, default 32: width of the period counter and cfg_period.
REQ-003 Parameter DEF_PERIOD, default 4: tick period in clk cycles after reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  run request; high starts ticking, low stops at the end of the current period.
REQ-007 cfg_valid  input  1  new-period offer.
REQ-008 cfg_period  input  CNT_W  offered period in cycles; value 0 SHALL be stored as 1.
REQ-009 cfg_ready  output  1  high when no configuration is pending.
REQ-010 req  input  NREQ  level request per requester, bit i = requester i.
REQ-011 tick  output  1  one-cycle pulse, once per period while active.
REQ-012 grant  output  NREQ  one-hot or zero, valid only in the tick cycle.
REQ-013 busy  output  1  high in every state other than IDLE.

Function
REQ-014 FSM states: IDLE, RUN and DRAIN.
REQ-015 IDLE: counter held at 1; tick and grant low; en=1 moves to RUN on the next edge.
REQ-016 RUN: counter increments by 1 per cycle through 1..period; wrap cycle = counter equals period; at wrap the counter SHALL reload 1.
REQ-017 RUN with en=0: move to DRAIN; counting continues undisturbed.
REQ-018 DRAIN at the wrap cycle: emit the final tick, then go to IDLE.
REQ-019 DRAIN with en=1 before the wrap: return to RUN without altering the counter.
REQ-020 tick SHALL be registered high exactly in the cycle after each wrap cycle, giving 1-cycle latency; period 1 gives a continuous tick.
REQ-021 Arbitration: req is sampled in the wrap cycle; grant is registered alongside tick.
REQ-022 Arbitration order is round-robin, starting from pointer ptr.
REQ-023 Granted index i sets ptr to (i+1) mod NREQ.
REQ-024 No request at wrap: grant=0 and ptr unchanged.
REQ-025 A req deasserted before the wrap cycle SHALL NOT be granted.
REQ-026 cfg accept: cfg_valid && cfg_ready stores the value as pending and drives cfg_ready low.
REQ-027 In RUN/DRAIN, pending SHALL take effect at the first wrap strictly after acceptance; that wrap still uses the old period; cfg_ready returns high the following cycle.
REQ-028 In IDLE, pending SHALL be applied on the cycle after acceptance.
REQ-029 A cfg_valid offer while cfg_ready=0 SHALL be ignored, never overwriting pending.
REQ-030 Counter comparison SHALL be unsigned CNT_W-bit with no overflow.
REQ-031 A period shrunk below the current count cannot occur, because changes apply only at a wrap.

Reset
REQ-032 On rst_n low, asynchronously: state=IDLE, counter=1, period=DEF_PERIOD, pending cleared, ptr=0.
REQ-033 On rst_n low, outputs: tick=0, grant=0, busy=0, cfg_ready=1.
REQ-034 Reset mid-period SHALL discard any tick or grant in flight.
REQ-035 After rst_n rises, behaviour SHALL match a fresh IDLE.

Structure
REQ-036 Package tick_sched_pkg SHALL hold the state enum (IDLE/RUN/DRAIN) and constants DEF_PERIOD and CNT_W.
REQ-037 Sub-module rr_arbiter: purely combinational NREQ-wide round-robin pick taking req and ptr, returning a one-hot grant and a found flag; instantiated once.

Verification
REQ-038 Reset, en=1, period 4, req=0001 -> tick every 4 cycles; first tick 5 cycles after en sampled high; grant=0001 on each tick.
REQ-039 req=1111 held, period 3 -> grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive ticks.
REQ-040 cfg_period=2 accepted mid-period of a period-6 run -> the current period completes at 6, then ticks every 2 cycles; cfg_ready low until the wrap+1 cycle.
REQ-041 en dropped at count 2 of period 5 -> one more tick at the wrap, then busy=0.
REQ-042 en dropped then re-raised within the same period -> no gap in the tick cadence.
REQ-043 Other directed cases:
- cfg_period=0 -> tick every cycle.
- Second cfg_valid while pending -> ignored.
- rst_n low at count 3 -> no tick; all outputs at reset values immediately.
